// File: rtl/pc_pkg.sv
// pc_pkg: shared types, default sizes and control-priority decode for the program counter stage.
package pc_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int STACK_DEPTH_DEF = 8;
  localparam int DELAY_W_DEF = 32;
  typedef enum logic {OCIOSO, ESPERA} estado_e;
  typedef enum logic [2:0] {C_DELAY, C_RET, C_CALL, C_JUMP, C_BRANCH, C_SEQ} ctrl_e;
  // First match wins; unlisted pilha combinations land on the lower rules.
  function automatic ctrl_e decode(input logic dly, sal, des, pil, emp);
    return dly ? C_DELAY :
           (des & pil & !emp) ? C_RET :
           (sal & pil & emp) ? C_CALL :
           (sal & !pil) ? C_JUMP :
           (des & !pil) ? C_BRANCH : C_SEQ;
  endfunction
endpackage

// File: rtl/contador_de_programa_if.sv
// contador_de_programa_if: control-unit to program-counter bundle.
interface contador_de_programa_if #(
  parameter int ADDR_W = 10,
  parameter int DELAY_W = 32
);
  logic enable, salto, desvio, pilha, emp_desemp, cond, delay;
  logic [ADDR_W-1:0] alvo;
  logic [DELAY_W-1:0] delay_count;
  logic [ADDR_W-1:0] pc;
  logic stall, stack_overflow, stack_underflow;
  modport master (
    output enable, salto, desvio, pilha, emp_desemp, cond, delay, alvo, delay_count,
    input pc, stall, stack_overflow, stack_underflow
  );
  modport slave (
    input enable, salto, desvio, pilha, emp_desemp, cond, delay, alvo, delay_count,
    output pc, stall, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/contador_de_programa_pilha_retorno.sv
// pilha_retorno: return-address LIFO; contents are not reset, only the pointer.
module pilha_retorno #(
  parameter int DEPTH = 8,
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int SP_W = $clog2(DEPTH) + 1;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-2:0] wr_idx, rd_idx;
  logic [W-1:0] mem_q [DEPTH];
  assign full = sp_q == SP_W'(DEPTH);
  assign empty = sp_q == '0;
  assign wr_idx = sp_q[SP_W-2:0];
  assign rd_idx = wr_idx - (SP_W-1)'(1);
  assign top = mem_q[rd_idx];
  always_comb sp_d = (push && !full) ? sp_q + SP_W'(1) :
                     (pop && !empty) ? sp_q - SP_W'(1) : sp_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sp_q <= '0;
    else sp_q <= sp_d;
  always_ff @(posedge clock)
    if (push && !full) mem_q[wr_idx] <= din;
endmodule

// File: rtl/contador_de_programa.sv
// contador_de_programa: next-address generation with call/return stack and delay stall.
module contador_de_programa
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input logic clock,
  input logic reset_n,
  contador_de_programa_if.slave bus
);
  estado_e estado_q, estado_d;
  ctrl_e ctrl;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d, push, pop, full, empty;
  assign pc_inc = pc_q + ADDR_W'(1);
  assign ctrl = decode(bus.delay, bus.salto, bus.desvio, bus.pilha, bus.emp_desemp);
  always_comb begin
    pc_d = pc_q;
    cnt_d = cnt_q;
    estado_d = estado_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push = 1'b0;
    pop = 1'b0;
    if (bus.enable && estado_q == ESPERA) begin
      cnt_d = cnt_q - DELAY_W'(1);
      estado_d = (cnt_q == DELAY_W'(1)) ? OCIOSO : ESPERA;
      pc_d = (cnt_q == DELAY_W'(1)) ? pc_inc : pc_q;
    end else if (bus.enable) begin
      case (ctrl)
        C_DELAY: begin
          pc_d = (bus.delay_count == '0) ? pc_inc : pc_q;
          cnt_d = bus.delay_count;
          estado_d = (bus.delay_count == '0) ? OCIOSO : ESPERA;
        end
        C_RET: begin
          pc_d = empty ? pc_inc : top;
          pop = !empty;
          unf_d = unf_q | empty;
        end
        C_CALL: begin
          pc_d = bus.alvo;
          push = !full;
          ovf_d = ovf_q | full;
        end
        C_JUMP: pc_d = bus.alvo;
        C_BRANCH: pc_d = bus.cond ? bus.alvo : pc_inc;
        default: pc_d = pc_inc;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      estado_q <= OCIOSO;
      pc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  pilha_retorno #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_pilha (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din(pc_inc),
    .top(top),
    .full(full),
    .empty(empty)
  );
  assign bus.pc = pc_q;
  assign bus.stall = estado_q == ESPERA;
  assign bus.stack_overflow = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_contador_de_programa.sv
// tb_contador_de_programa: directed stimulus feeding a scoreboard queue; a monitor pops and compares.
module tb_contador_de_programa;
  typedef struct {
    string n;
    logic [9:0] pc;
    logic s, o, u;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic eo = 1'b0, eu = 1'b0;
  int n_chk = 0, n_pass = 0;
  exp_t q[$];
  contador_de_programa_if bus ();
  contador_de_programa dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic drive_idle(input logic en);
    bus.enable = en;
    bus.salto = 1'b0;
    bus.desvio = 1'b0;
    bus.pilha = 1'b0;
    bus.emp_desemp = 1'b0;
    bus.cond = 1'b0;
    bus.delay = 1'b0;
    bus.alvo = '0;
    bus.delay_count = '0;
  endtask
  task automatic step(input string op, input logic [9:0] a, input logic c,
                      input logic [31:0] n, input logic [9:0] epc, input logic es);
    @(negedge clock);
    bus.enable = op != "off";
    bus.salto = op == "jmp" || op == "call" || op == "off";
    bus.desvio = op == "br" || op == "ret";
    bus.pilha = op == "call" || op == "ret";
    bus.emp_desemp = op == "call";
    bus.cond = c;
    bus.alvo = a;
    bus.delay = op == "dly";
    bus.delay_count = n;
    q.push_back('{op, epc, es, eo, eu});
  endtask
  task automatic areset();
    @(negedge clock);
    drive_idle(1'b0);
    reset_n = 1'b0;
    eo = 1'b0;
    eu = 1'b0;
    q.push_back('{"reset", 10'h000, 1'b0, 1'b0, 1'b0});
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial forever begin
    exp_t e;
    @(posedge clock or negedge reset_n);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_chk++;
      if (bus.pc === e.pc && bus.stall === e.s && bus.stack_overflow === e.o && bus.stack_underflow === e.u)
        n_pass++;
      else
        $display("FAIL %s #%0d: got pc=%h stall=%b ovf=%b unf=%b, want pc=%h stall=%b ovf=%b unf=%b",
                 e.n, n_chk, bus.pc, bus.stall, bus.stack_overflow, bus.stack_underflow,
                 e.pc, e.s, e.o, e.u);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
  initial begin
    drive_idle(1'b0);
    areset();
    for (int i = 1; i <= 4; i++) step("idle", 0, 0, 0, 10'(i), 0);
    step("jmp", 10'h010, 0, 0, 10'h010, 0);
    step("jmp", 10'h155, 0, 0, 10'h155, 0);
    step("br", 10'h020, 0, 0, 10'h156, 0);
    step("br", 10'h020, 1, 0, 10'h020, 0);
    step("jmp", 10'h005, 0, 0, 10'h005, 0);
    step("call", 10'h200, 0, 0, 10'h200, 0);
    step("ret", 10'h000, 0, 0, 10'h006, 0);
    step("jmp", 10'h040, 0, 0, 10'h040, 0);
    step("dly", 0, 0, 3, 10'h040, 1);
    step("jmp", 10'h3AA, 0, 0, 10'h040, 1);
    step("idle", 0, 0, 0, 10'h040, 1);
    step("idle", 0, 0, 0, 10'h041, 0);
    step("dly", 0, 0, 0, 10'h042, 0);
    for (int i = 0; i < 8; i++) step("call", 10'h100 + 10'(i * 16), 0, 0, 10'h100 + 10'(i * 16), 0);
    eo = 1'b1;
    step("call", 10'h180, 0, 0, 10'h180, 0);
    for (int j = 1; j <= 7; j++) step("ret", 0, 0, 0, 10'h101 + 10'((7 - j) * 16), 0);
    step("ret", 0, 0, 0, 10'h043, 0);
    eu = 1'b1;
    step("ret", 0, 0, 0, 10'h044, 0);
    step("jmp", 10'h3FF, 0, 0, 10'h3FF, 0);
    step("idle", 0, 0, 0, 10'h000, 0);
    step("jmp", 10'h3FF, 0, 0, 10'h3FF, 0);
    step("call", 10'h123, 0, 0, 10'h123, 0);
    step("ret", 0, 0, 0, 10'h000, 0);
    step("idle", 0, 0, 0, 10'h001, 0);
    step("off", 10'h2AA, 0, 0, 10'h001, 0);
    step("dly", 0, 0, 2, 10'h001, 1);
    for (int i = 0; i < 5; i++) step("off", 10'h2AA, 0, 0, 10'h001, 1);
    step("idle", 0, 0, 0, 10'h001, 1);
    step("idle", 0, 0, 0, 10'h002, 0);
    step("dly", 0, 0, 5, 10'h002, 1);
    step("idle", 0, 0, 0, 10'h002, 1);
    areset();
    step("idle", 0, 0, 0, 10'h001, 0);
    eu = 1'b1;
    step("ret", 0, 0, 0, 10'h002, 0);
    step("idle", 0, 0, 0, 10'h003, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
